axis_stream_alu: RTL and testbench

- Custom-hardware stage between the datamover MM2S stream output (h2s) and its S2MM stream input (s2h). It replaces the plain loopback FIFO.
- Applies a per-packet selectable 64-bit operation to each beat: pass, add, xor or byte-swap.
- Buffers through a registered pipeline with a skid slot, so backpressure never drops or duplicates a beat.
- Configured and monitored through the set/get register bus from the AXI4-Lite slave.

---
 rtl/accel_pkg.sv | 56 +++++
 rtl/axis_skid_buf.sv | 78 +++++++
 rtl/axis_stream_alu.sv | 199 +++++++++++++++++++
 tb/tb_axis_stream_alu.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
//============================================================================
// Module      : accel_pkg
// Description : Shared encodings for the stream accelerator stages: ALU
//               opcodes, register word indices, FSM states and the ALU
//               transform function.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package accel_pkg;

    typedef enum logic [1:0] {
        OP_PASS  = 2'd0,
        OP_ADD   = 2'd1,
        OP_XOR   = 2'd2,
        OP_BSWAP = 2'd3
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Register word index within the page (addr[4:2])
    localparam logic [2:0] C_REG_CTRL       = 3'd0;
    localparam logic [2:0] C_REG_OPERAND_LO = 3'd1;
    localparam logic [2:0] C_REG_OPERAND_HI = 3'd2;
    localparam logic [2:0] C_REG_PKT_COUNT  = 3'd3;
    localparam logic [2:0] C_REG_LAST_LEN   = 3'd4;
    localparam logic [2:0] C_REG_CUR_LEN    = 3'd5;

    localparam logic [15:0] C_LEN_MAX = 16'hFFFF;

    function automatic logic [63:0] alu_apply(
        input op_e         op,
        input logic [63:0] data,
        input logic [63:0] operand
    );
        logic [63:0] res;
        res = data;
        case (op)
            OP_ADD:   res = data + operand;
            OP_XOR:   res = data ^ operand;
            OP_BSWAP: begin
                for (int i = 0; i < 8; i++) begin
                    res[8*i +: 8] = data[8*(7-i) +: 8];
                end
            end
            default:  res = data;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_skid_buf.sv
//============================================================================
// Module      : axis_skid_buf
// Description : Generic 2-entry valid/ready skid buffer (output register
//               plus one skid slot) with a registered upstream ready.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module axis_skid_buf #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_valid;
    logic             r_ready;

    logic w_accept;
    logic w_out_free;
    logic w_skid_valid_next;

    assign w_accept   = i_valid && r_ready;
    assign w_out_free = !r_out_valid || i_ready;

    // Ready is simply "skid empty next cycle", so it never depends on i_ready
    // combinationally.
    always_comb begin
        w_skid_valid_next = r_skid_valid;
        if (w_out_free) begin
            w_skid_valid_next = 1'b0;
        end else if (w_accept) begin
            w_skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_data  <= r_skid_data;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= w_accept;
                    if (w_accept) begin
                        r_out_data <= i_data;
                    end
                end
            end else if (w_accept) begin
                r_skid_data <= i_data;
            end
            r_skid_valid <= w_skid_valid_next;
            r_ready      <= !w_skid_valid_next;
        end
    end

    assign o_ready = r_ready;
    assign o_data  = r_out_data;
    assign o_valid = r_out_valid;

endmodule

`default_nettype wire

// File: rtl/axis_stream_alu.sv
//============================================================================
// Module      : axis_stream_alu
// Description : Per-packet 64-bit stream ALU (pass/add/xor/byte-swap) between
//               MM2S and S2MM, with set/get register page and packet counters.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module axis_stream_alu
    import accel_pkg::*;
#(
    parameter int          C_AXIS_DATA_WIDTH  = 64,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [15:0] C_REG_BASE         = 16'h0000
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] set_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] set_data,
    input  logic                          set_stb,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] get_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] get_data,
    input  logic                          get_stb,
    output logic                          pkt_done
);

    // Live configuration (register page)
    logic                          r_ctrl_enable;
    op_e                           r_ctrl_op;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_operand_lo;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_operand_hi;

    // Configuration frozen for the packet in flight
    op_e                           r_act_op;
    logic [C_AXIS_DATA_WIDTH-1:0]  r_act_operand;

    state_e                        r_state;
    state_e                        w_state_next;
    logic                          r_accept_en;
    logic                          w_accept_en_next;
    logic                          w_enable_next;

    logic [31:0]                   r_pkt_count;
    logic [15:0]                   r_last_len;
    logic [15:0]                   r_cur_len;
    logic                          r_pkt_done;

    logic                          w_set_hit;
    logic                          w_get_hit;
    logic                          w_in_hs;
    logic                          w_out_hs;
    logic                          w_buf_ready;
    op_e                           w_op;
    logic [C_AXIS_DATA_WIDTH-1:0]  w_operand;
    logic [C_AXIS_DATA_WIDTH-1:0]  w_result;
    logic [C_AXIS_DATA_WIDTH:0]    w_buf_out;
    logic                          w_unused;

    assign w_set_hit = set_stb && (set_addr[15:5] == C_REG_BASE[15:5]);
    assign w_get_hit = (get_addr[15:5] == C_REG_BASE[15:5]);
    assign w_unused  = &{1'b0, get_stb,
                         set_addr[C_S_AXI_ADDR_WIDTH-1:16], set_addr[1:0],
                         get_addr[C_S_AXI_ADDR_WIDTH-1:16], get_addr[1:0]};

    assign s_axis_tready = w_buf_ready && r_accept_en;
    assign w_in_hs       = s_axis_tvalid && s_axis_tready;
    assign w_out_hs      = m_axis_tvalid && m_axis_tready;

    // ------------------------------------------------------------------
    // FSM and upstream-accept gate
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_accept_en <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_accept_en <= w_accept_en_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_in_hs && !s_axis_tlast) w_state_next = ST_BUSY;
            ST_BUSY: if (w_in_hs && s_axis_tlast)  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        // A CTRL write lands this edge, so the gate sees the new ENABLE at once
        w_enable_next = (w_set_hit && set_addr[4:2] == C_REG_CTRL) ? set_data[0]
                                                                   : r_ctrl_enable;
        w_accept_en_next = (w_state_next == ST_BUSY) || w_enable_next;
    end

    // First beat of a packet uses the live config, which is latched for the rest
    always_comb begin
        w_op      = r_act_op;
        w_operand = r_act_operand;
        if (r_state == ST_IDLE) begin
            w_op      = r_ctrl_op;
            w_operand = {r_operand_hi, r_operand_lo};
        end
    end

    assign w_result = alu_apply(w_op, s_axis_tdata, w_operand);

    axis_skid_buf #(
        .WIDTH (C_AXIS_DATA_WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .aresetn (aresetn),
        .i_data  ({s_axis_tlast, w_result}),
        .i_valid (w_in_hs),
        .o_ready (w_buf_ready),
        .o_data  (w_buf_out),
        .o_valid (m_axis_tvalid),
        .i_ready (m_axis_tready)
    );

    assign m_axis_tdata = w_buf_out[C_AXIS_DATA_WIDTH-1:0];
    assign m_axis_tlast = w_buf_out[C_AXIS_DATA_WIDTH];
    assign pkt_done     = r_pkt_done;

    // ------------------------------------------------------------------
    // Register file and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_ctrl_enable <= 1'b0;
            r_ctrl_op     <= OP_PASS;
            r_operand_lo  <= '0;
            r_operand_hi  <= '0;
            r_act_op      <= OP_PASS;
            r_act_operand <= '0;
            r_pkt_count   <= '0;
            r_last_len    <= '0;
            r_cur_len     <= '0;
            r_pkt_done    <= 1'b0;
        end else begin
            if (w_set_hit) begin
                case (set_addr[4:2])
                    C_REG_CTRL: begin
                        r_ctrl_enable <= set_data[0];
                        r_ctrl_op     <= op_e'(set_data[2:1]);
                    end
                    C_REG_OPERAND_LO: r_operand_lo <= set_data;
                    C_REG_OPERAND_HI: r_operand_hi <= set_data;
                    default: ;
                endcase
            end

            if (w_in_hs && r_state == ST_IDLE) begin
                r_act_op      <= r_ctrl_op;
                r_act_operand <= {r_operand_hi, r_operand_lo};
            end

            if (w_in_hs) begin
                if (s_axis_tlast) begin
                    r_last_len <= (r_cur_len == C_LEN_MAX) ? C_LEN_MAX : r_cur_len + 16'd1;
                    r_cur_len  <= '0;
                end else if (r_cur_len != C_LEN_MAX) begin
                    r_cur_len <= r_cur_len + 16'd1;
                end
            end

            r_pkt_done <= w_out_hs && m_axis_tlast;
            if (w_out_hs && m_axis_tlast) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    always_comb begin
        get_data = '0;
        if (w_get_hit) begin
            case (get_addr[4:2])
                C_REG_CTRL:       get_data = C_S_AXI_DATA_WIDTH'({r_ctrl_op, r_ctrl_enable});
                C_REG_OPERAND_LO: get_data = r_operand_lo;
                C_REG_OPERAND_HI: get_data = r_operand_hi;
                C_REG_PKT_COUNT:  get_data = C_S_AXI_DATA_WIDTH'(r_pkt_count);
                C_REG_LAST_LEN:   get_data = C_S_AXI_DATA_WIDTH'(r_last_len);
                C_REG_CUR_LEN:    get_data = C_S_AXI_DATA_WIDTH'(r_cur_len);
                default:          get_data = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_stream_alu.sv
//============================================================================
// Module      : tb_axis_stream_alu
// Description : Self-checking bench for axis_stream_alu: reference model with
//               expected-beat queue plus directed literal checks.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axis_stream_alu;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] set_addr;
    logic [31:0] set_data;
    logic        set_stb;
    logic [31:0] get_addr;
    logic [31:0] get_data;
    logic        get_stb;
    logic        pkt_done;

    always #5 clk = ~clk;

    axis_stream_alu dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .set_addr      (set_addr),
        .set_data      (set_data),
        .set_stb       (set_stb),
        .get_addr      (get_addr),
        .get_data      (get_data),
        .get_stb       (get_stb),
        .pkt_done      (pkt_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic [31:0] c;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] got_q[$];
    logic [1:0]  m_op;
    logic [31:0] m_lo, m_hi;
    logic [1:0]  a_op;
    logic [63:0] a_opnd;
    bit          m_in_pkt;
    int unsigned m_pkt, m_last, m_cur;
    bit          exp_done, prev_stall, lat_check, rand_rdy;
    logic [64:0] prev_out;
    logic [31:0] cyc = 0;

    function automatic logic [63:0] model_op(input logic [1:0] op, input logic [63:0] d,
                                             input logic [63:0] k);
        case (op)
            2'd1:    return d + k;
            2'd2:    return d ^ k;
            2'd3:    return {<<8{d}};
            default: return d;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        beat_t b;
        if (!aresetn) begin
            exp_q.delete();
            m_op = 0; m_lo = 0; m_hi = 0; a_op = 0; a_opnd = 0; m_in_pkt = 0;
            m_pkt = 0; m_last = 0; m_cur = 0; exp_done = 0; prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", m_axis_tvalid, 1);
                chk("hold_data", m_axis_tdata, prev_out[63:0]);
                chk("hold_last", m_axis_tlast, prev_out[64]);
            end
            chk("pkt_done", pkt_done, exp_done);
            exp_done = 0;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got 0x%0h expected none", m_axis_tdata);
                end else begin
                    b = exp_q.pop_front();
                    chk("out_data", m_axis_tdata, b.d);
                    chk("out_last", m_axis_tlast, b.l);
                    if (lat_check) chk("latency", cyc - b.c, 1);
                end
                got_q.push_back(m_axis_tdata);
                if (m_axis_tlast) begin
                    exp_done = 1;
                    m_pkt++;
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_out   = {m_axis_tlast, m_axis_tdata};

            if (s_axis_tvalid && s_axis_tready) begin
                if (!m_in_pkt) begin
                    a_op   = m_op;
                    a_opnd = {m_hi, m_lo};
                end
                b.d = model_op(a_op, s_axis_tdata, a_opnd);
                b.l = s_axis_tlast;
                b.c = cyc;
                exp_q.push_back(b);
                m_in_pkt = !s_axis_tlast;
                if (s_axis_tlast) begin
                    m_last = (m_cur + 1 > 32'hFFFF) ? 32'hFFFF : m_cur + 1;
                    m_cur  = 0;
                end else if (m_cur < 32'hFFFF) begin
                    m_cur++;
                end
            end

            if (set_stb && set_addr[31:5] == 27'd0) begin
                case (set_addr[4:2])
                    3'd0: m_op = set_data[2:1];
                    3'd1: m_lo = set_data;
                    3'd2: m_hi = set_data;
                    default: ;
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        set_addr = a;
        set_data = d;
        set_stb  = 1'b1;
        @(posedge clk);
        #1;
        set_stb  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [63:0] e, input string n);
        get_addr = a;
        #1;
        chk(n, get_data, e);
    endtask

    task automatic send(input logic [63:0] d, input logic l);
        int t;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (s_axis_tready) break;
        end
        if (t == 1000) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got no s_axis_tready expected accept of 0x%0h", d);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 1000; t++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !m_axis_tvalid) break;
        end
        if (t == 1000) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        aresetn = 1'b0;
        s_axis_tdata = '0; s_axis_tlast = 0; s_axis_tvalid = 0;
        m_axis_tready = 0; set_addr = 0; set_data = 0; set_stb = 0;
        get_addr = 0; get_stb = 0; rand_rdy = 0; lat_check = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tlast", m_axis_tlast, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_pkt_done", pkt_done, 0);
        aresetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ready_without_enable", s_axis_tready, 0);
        rd(32'h00, 0, "ctrl_after_reset");

        // Pass, 4-beat packet
        m_axis_tready = 1;
        wr(32'h00, 32'h1);
        chk("ready_after_enable", s_axis_tready, 1);
        lat_check = 1;
        got_q.delete();
        for (int i = 1; i <= 4; i++) send(64'(i), i == 4);
        drain();
        lat_check = 0;
        chk("pass_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("pass_beat", got_q[i], 64'(i + 1));
        rd(32'h0C, 1, "pkt_count_1");
        rd(32'h10, 4, "last_len_4");
        rd(32'h14, 0, "cur_len_0");

        // Add with 64-bit wrap
        wr(32'h04, 32'h2);
        wr(32'h08, 32'h0);
        wr(32'h00, 32'h3);
        lat_check = 1;
        got_q.delete();
        send(64'hFFFF_FFFF_FFFF_FFFF, 1);
        drain();
        lat_check = 0;
        chk("add_count", got_q.size(), 1);
        chk("add_wrap", got_q[0], 64'h1);
        rd(32'h10, 1, "last_len_1");

        // Byte-swap under random backpressure
        wr(32'h00, 32'h7);
        got_q.delete();
        rand_rdy = 1;
        for (int i = 0; i < 16; i++)
            send(64'h0011_2233_4455_6677 + 64'(i) * 64'h0101_0101_0101_0101, i == 15);
        drain();
        rand_rdy = 0;
        m_axis_tready = 1;
        chk("bswap_count", got_q.size(), 16);
        chk("bswap_first", got_q[0], 64'h7766_5544_3322_1100);
        chk("bswap_last", got_q[15], 64'h8675_6453_4231_200F);
        rd(32'h10, 16, "last_len_16");

        // Config change mid-packet
        wr(32'h04, 32'hFF);
        wr(32'h08, 32'h0);
        wr(32'h00, 32'h5);
        got_q.delete();
        send(64'h100, 0);
        send(64'h101, 0);
        wr(32'h00, 32'h1);
        for (int i = 2; i <= 5; i++) send(64'h100 + 64'(i), i == 5);
        send(64'hABCD, 0);
        send(64'hABCE, 1);
        drain();
        chk("cfg_count", got_q.size(), 8);
        chk("cfg_xor_b1", got_q[1], 64'h1FE);
        chk("cfg_xor_b5", got_q[5], 64'h1FA);
        chk("cfg_pass_b0", got_q[6], 64'hABCD);
        chk("cfg_pass_b1", got_q[7], 64'hABCE);

        // Disable mid-packet, then re-enable
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) wr(32'h00, 32'h0);
            send(64'h200 + 64'(i), i == 7);
        end
        drain();
        chk("dis_count", got_q.size(), 8);
        chk("dis_last_beat", got_q[7], 64'h207);
        s_axis_tdata = 64'hDEAD; s_axis_tlast = 1; s_axis_tvalid = 1;
        repeat (5) begin
            @(negedge clk);
            chk("disabled_ready", s_axis_tready, 0);
        end
        @(posedge clk);
        #1;
        wr(32'h00, 32'h1);
        send(64'hDEAD, 1);
        drain();
        chk("reenable_count", got_q.size(), 9);
        chk("reenable_beat", got_q[8], 64'hDEAD);
        rd(32'h10, 1, "last_len_reenable");
        rd(32'h0C, 64'(m_pkt), "pkt_count_model");

        // Register map edges
        wr(32'h0C, 32'h1234);
        rd(32'h0C, 64'(m_pkt), "ro_write_ignored");
        rd(32'h1C, 0, "unmapped_read");
        rd(32'h20, 0, "off_page_read");
        wr(32'h24, 32'h55);
        rd(32'h04, 64'(m_lo), "off_page_write_ignored");
        rd(32'h04, 64'hFF, "operand_lo_value");

        // Async reset with the skid slot full
        m_axis_tready = 0;
        send(64'h300, 0);
        send(64'h301, 0);
        @(negedge clk);
        chk("skid_full_ready", s_axis_tready, 0);
        chk("skid_full_valid", m_axis_tvalid, 1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_m_tvalid", m_axis_tvalid, 0);
        chk("arst_s_tready", s_axis_tready, 0);
        chk("arst_pkt_done", pkt_done, 0);
        chk("arst_m_tdata", m_axis_tdata, 0);
        rd(32'h0C, 0, "arst_pkt_count");
        rd(32'h10, 0, "arst_last_len");
        rd(32'h14, 0, "arst_cur_len");
        rd(32'h00, 0, "arst_ctrl");
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        m_axis_tready = 1;
        @(posedge clk);
        #1;
        chk("post_reset_ready", s_axis_tready, 0);
        wr(32'h00, 32'h1);
        lat_check = 1;
        got_q.delete();
        send(64'h55, 1);
        drain();
        lat_check = 0;
        chk("post_reset_count", got_q.size(), 1);
        chk("post_reset_beat", got_q[0], 64'h55);
        rd(32'h0C, 1, "post_reset_pkt_count");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
